// File: rtl/sinfonia_pkg.sv
// Shared note definitions for the note link: codes, pitch table, half-period helper
// and the player FSM state type.
package sinfonia_pkg;

    localparam int unsigned NOTA_PAUSA = 0;
    localparam int unsigned NOTA_DO    = 1;
    localparam int unsigned NOTA_RE    = 2;
    localparam int unsigned NOTA_MI    = 3;
    localparam int unsigned NOTA_FA    = 4;
    localparam int unsigned NOTA_SOL   = 5;
    localparam int unsigned NOTA_LA    = 6;
    localparam int unsigned NOTA_SI    = 7;

    localparam int unsigned FREQ_HZ [1:7] = '{262, 294, 330, 349, 392, 440, 494};

    // Half-period in clock cycles, floored, never below one cycle.
    function automatic int unsigned meio_periodo(input int unsigned clk_hz,
                                                 input int unsigned freq);
        int unsigned hp;
        hp = clk_hz / (2 * freq);
        return (hp == 0) ? 1 : hp;
    endfunction

    typedef enum logic [1:0] {
        OCIOSO,
        TOCANDO,
        FIM
    } estado_t;

endpackage

// File: rtl/receptor_nota_buzzer_gerador_tom.sv
// Square-wave divider: toggles onda every meio_periodo enabled cycles; zera clears
// both the divider and the wave.
module gerador_tom #(
    parameter int unsigned LARG = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            habilita,
    input  logic            zera,
    input  logic [LARG-1:0] meio_periodo,
    output logic            onda
);

    logic [LARG-1:0] cnt_q, cnt_d;
    logic            onda_q, onda_d;

    always_comb begin
        cnt_d  = cnt_q;
        onda_d = onda_q;
        if (zera) begin
            cnt_d  = '0;
            onda_d = 1'b0;
        end else if (habilita) begin
            if (cnt_q == meio_periodo - LARG'(1)) begin
                cnt_d  = '0;
                onda_d = ~onda_q;
            end else begin
                cnt_d = cnt_q + LARG'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            onda_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            onda_q <= onda_d;
        end
    end

    assign onda = onda_q;

endmodule

// File: rtl/receptor_nota_buzzer.sv
// Note-link receiver: latches one 3-bit note per strobe and plays it on the buzzer
// for DUR cycles, then pulses done.
module receptor_nota_buzzer
    import sinfonia_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned DURACAO_MS = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid,
    input  logic [2:0] nota,
    output logic       buzzer,
    output logic       busy,
    output logic       done,
    output logic [2:0] db_nota
);

    localparam int unsigned DUR    = (CLK_HZ / 1000) * DURACAO_MS;
    localparam int unsigned DW     = (DUR > 1) ? $clog2(DUR) : 1;
    localparam int unsigned HP_MAX = meio_periodo(CLK_HZ, FREQ_HZ[NOTA_DO]);
    localparam int unsigned PW     = $clog2(HP_MAX + 1);

    // Entry 0 (rest) is never used by the divider; it only keeps the table dense.
    localparam logic [PW-1:0] HP_TAB [8] = '{
        PW'(1),
        PW'(meio_periodo(CLK_HZ, FREQ_HZ[NOTA_DO])),
        PW'(meio_periodo(CLK_HZ, FREQ_HZ[NOTA_RE])),
        PW'(meio_periodo(CLK_HZ, FREQ_HZ[NOTA_MI])),
        PW'(meio_periodo(CLK_HZ, FREQ_HZ[NOTA_FA])),
        PW'(meio_periodo(CLK_HZ, FREQ_HZ[NOTA_SOL])),
        PW'(meio_periodo(CLK_HZ, FREQ_HZ[NOTA_LA])),
        PW'(meio_periodo(CLK_HZ, FREQ_HZ[NOTA_SI]))
    };

    estado_t       estado_q, estado_d;
    logic [2:0]    nota_q, nota_d;
    logic [DW-1:0] dur_q, dur_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fim_dur;
    logic          zera;
    logic          habilita;
    logic [PW-1:0] hp_sel;

    assign fim_dur  = (estado_q == TOCANDO) && (dur_q == DW'(DUR - 1));
    // Wave is held at zero whenever the next cycle is not a playing cycle.
    assign zera     = (estado_q != TOCANDO) || fim_dur;
    assign habilita = (estado_q == TOCANDO) && (nota_q != 3'(NOTA_PAUSA));
    assign hp_sel   = HP_TAB[nota_q];

    always_comb begin
        estado_d = estado_q;
        nota_d   = nota_q;
        dur_d    = dur_q;
        unique case (estado_q)
            OCIOSO: begin
                if (valid) begin
                    nota_d   = nota;
                    dur_d    = '0;
                    estado_d = TOCANDO;
                end
            end
            TOCANDO: begin
                if (fim_dur) begin
                    dur_d    = '0;
                    estado_d = FIM;
                end else begin
                    dur_d = dur_q + DW'(1);
                end
            end
            FIM: estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
        busy_d = (estado_d != OCIOSO);
        done_d = (estado_d == FIM);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            nota_q   <= '0;
            dur_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            nota_q   <= nota_d;
            dur_q    <= dur_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    gerador_tom #(
        .LARG(PW)
    ) u_gerador_tom (
        .clock        (clock),
        .reset        (reset),
        .habilita     (habilita),
        .zera         (zera),
        .meio_periodo (hp_sel),
        .onda         (buzzer)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign db_nota = nota_q;

endmodule

// File: tb/tb_receptor_nota_buzzer.sv
// Self-checking bench for receptor_nota_buzzer with a cycle-offset reference model.
module tb_receptor_nota_buzzer;

    localparam int CLK_HZ     = 10_000;
    localparam int DURACAO_MS = 10;
    localparam int DUR        = (CLK_HZ / 1000) * DURACAO_MS;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       valid = 1'b0;
    logic [2:0] nota  = 3'd0;
    logic       buzzer;
    logic       busy;
    logic       done;
    logic [2:0] db_nota;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [2:0] last_code = 3'd0;
    int         freq_tab [8] = '{0, 262, 294, 330, 349, 392, 440, 494};

    receptor_nota_buzzer #(
        .CLK_HZ     (CLK_HZ),
        .DURACAO_MS (DURACAO_MS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .valid   (valid),
        .nota    (nota),
        .buzzer  (buzzer),
        .busy    (busy),
        .done    (done),
        .db_nota (db_nota)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected {busy, done, buzzer, db_nota} k edges after a note was strobed.
    function automatic logic [5:0] model(input logic [2:0] code, input int k);
        int   hp;
        logic bz;
        hp = (code == 3'd0) ? 1 : CLK_HZ / (2 * freq_tab[code]);
        bz = (code != 3'd0) && (k <= DUR) && ((((k - 1) / hp) % 2) == 1);
        return {1'b1, (k == DUR + 1), bz, code};
    endfunction

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            nota = 3'($urandom);
            n_chk++;
            if ({busy, done, buzzer, db_nota} !== {3'b000, last_code})
                $display("FAIL %s idle cyc=%0d got=%b exp=%b", tag, i,
                         {busy, done, buzzer, db_nota}, {3'b000, last_code});
            else
                n_pass++;
        end
    endtask

    // mode 0: quiet inputs; 1: random ignored strobes; 2: one strobe of code 7 at +40.
    task automatic play_note(input logic [2:0] code, input int mode, input string tag);
        logic [5:0] exp;
        valid = 1'b1;
        nota  = code;
        for (int k = 1; k <= DUR + 1; k++) begin
            step();
            valid = 1'b0;
            nota  = 3'($urandom);
            if (mode == 1 && $urandom_range(0, 7) == 0) valid = 1'b1;
            if (mode == 2 && k == 40) begin
                valid = 1'b1;
                nota  = 3'd7;
            end
            exp = model(code, k);
            n_chk++;
            if ({busy, done, buzzer, db_nota} !== exp)
                $display("FAIL %s k=%0d got=%b exp=%b", tag, k,
                         {busy, done, buzzer, db_nota}, exp);
            else
                n_pass++;
        end
        step();
        valid     = 1'b0;
        last_code = code;
        n_chk++;
        if ({busy, done, buzzer, db_nota} !== {3'b000, code})
            $display("FAIL %s end got=%b exp=%b", tag, {busy, done, buzzer, db_nota},
                     {3'b000, code});
        else
            n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b0;
        repeat (3) step();
        n_chk++;
        if ({busy, done, buzzer, db_nota} !== 6'd0)
            $display("FAIL reset got=%b exp=%b", {busy, done, buzzer, db_nota}, 6'd0);
        else
            n_pass++;
        reset     = 1'b0;
        last_code = 3'd0;
        idle_cycles(200, "reset_idle");
    endtask

    task automatic test_a4();
        play_note(3'd6, 0, "a4");
    endtask

    task automatic test_rest();
        play_note(3'd0, 1, "rest");
    endtask

    task automatic test_ignored_strobe();
        play_note(3'd1, 2, "ignored");
        idle_cycles(20, "ignored_after");
    endtask

    task automatic test_reset_mid_note();
        logic [5:0] exp;
        valid = 1'b1;
        nota  = 3'd7;
        for (int k = 1; k <= 50; k++) begin
            step();
            valid = 1'b0;
            nota  = 3'($urandom);
            exp   = model(3'd7, k);
            n_chk++;
            if ({busy, done, buzzer, db_nota} !== exp)
                $display("FAIL reset_mid k=%0d got=%b exp=%b", k,
                         {busy, done, buzzer, db_nota}, exp);
            else
                n_pass++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_chk++;
        if ({busy, done, buzzer, db_nota} !== 6'd0)
            $display("FAIL reset_mid abort got=%b exp=%b", {busy, done, buzzer, db_nota},
                     6'd0);
        else
            n_pass++;
        last_code = 3'd0;
        idle_cycles(30, "reset_mid_idle");
        play_note(3'd6, 1, "after_reset");
    endtask

    task automatic test_reset_and_valid();
        reset = 1'b1;
        valid = 1'b1;
        nota  = 3'd5;
        step();
        reset = 1'b0;
        valid = 1'b0;
        n_chk++;
        if ({busy, done, buzzer, db_nota} !== 6'd0)
            $display("FAIL reset_valid got=%b exp=%b", {busy, done, buzzer, db_nota}, 6'd0);
        else
            n_pass++;
        last_code = 3'd0;
        idle_cycles(5, "reset_valid_idle");
    endtask

    task automatic test_back_to_back();
        play_note(3'd5, 1, "b2b_first");
        play_note(3'd3, 0, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            play_note(3'($urandom), int'($urandom_range(0, 1)), "random");
            idle_cycles(int'($urandom_range(0, 3)), "random_gap");
        end
    endtask

    initial begin
        test_reset();
        test_a4();
        test_rest();
        test_ignored_strobe();
        test_reset_mid_note();
        test_reset_and_valid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
